// File: rtl/div_ctrl.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for the execute stage; one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN adds a ZERO state that short-circuits a zero divisor.
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  // Handshake: start_i is a level request held until the result is taken; ready_o marks
  // result_o valid in END, and dropping start_i while ready_o=1 is the acceptance.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
`ifdef DIV_ZERO_DETECT_EN
    ST_END  = 2'd2,
    ST_ZERO = 2'd3
`else
    ST_END  = 2'd2
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_stall;
  logic [4:0]  r_cnt;
  logic [31:0] r_divisor;
  logic [63:0] r_pr;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;
  logic        r_ready;

  logic [31:0] w_op1_abs;
  logic [31:0] w_op2_abs;
  logic [64:0] w_shift;
  logic [32:0] w_sub;
  logic [63:0] w_step;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // 65-bit partial remainder after the left shift; a clear borrow bit means the trial fits.
  assign w_shift = {r_pr, 1'b0};
  assign w_sub   = w_shift[64:32] - {1'b0, r_divisor};
  assign w_step  = w_sub[32] ? w_shift[63:0] : {w_sub[31:0], w_shift[31:1], 1'b1};

  assign w_quo_fix = r_neg_q ? (~w_step[31:0] + 32'd1) : w_step[31:0];
  assign w_rem_fix = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          w_stall = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          w_next_state = (opdata2_i == 32'd0) ? ST_ZERO : ST_ON;
`else
          w_next_state = ST_ON;
`endif
        end
      end
      ST_ON: begin
        w_stall = 1'b1;
        if (annul_i)              w_next_state = ST_IDLE;
        else if (r_cnt == 5'd31)  w_next_state = ST_END;
      end
`ifdef DIV_ZERO_DETECT_EN
      ST_ZERO: begin
        w_stall      = 1'b1;
        w_next_state = annul_i ? ST_IDLE : ST_END;
      end
`endif
      ST_END: begin
        if (!start_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_divisor <= '0;
      r_pr      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (start_i && !annul_i) begin
            r_cnt     <= '0;
            r_divisor <= w_op2_abs;
            r_pr      <= {32'd0, w_op1_abs};
            r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r   <= signed_div_i & opdata1_i[31];
          end
        end
        ST_ON: begin
          if (!annul_i) begin
            r_pr  <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_result <= {w_rem_fix, w_quo_fix};
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        ST_ZERO: r_result <= '0;
`endif
        ST_END: begin
          // ready is registered, so it rises one edge after END is entered
          if (start_i) begin
            r_ready <= 1'b1;
          end else begin
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end
        default: begin
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  assign result_o = (r_state == ST_END) ? r_result : 64'd0;
  assign ready_o  = (r_state == ST_END) & r_ready;
  assign stall_o  = w_stall;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a driver pushes expected results/latencies into a scoreboard,
// and a negedge monitor pops and compares on every rising ready_o.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  div_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_o      (stall_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          start_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: latency counts edges after the start-sampling edge
  logic        prev_ready = 1'b0;
  logic [63:0] mon_e;
  int          mon_l;
  int          mon_s;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got result %h expected no result", result_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        mon_s = start_q.pop_front();
        chk("result", result_o, mon_e);
        chk("latency", 64'(cyc - mon_s - 1), 64'(mon_l));
      end
    end
    prev_ready <= ready_o;
  end

  // driver tasks: always entered and left just after a falling edge
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int n;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp_res);
    lat_q.push_back(exp_lat);
    start_q.push_back(cyc);
    #1 chk("stall_idle_start", 64'(stall_o), 64'd1);
    @(negedge clk);
    opdata1_i = ~a;
    opdata2_i = b ^ 32'h5;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready_o after %0d cycles expected ready", n);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        void'(start_q.pop_front());
      end
    end else begin
      chk("stall_end", 64'(stall_o), 64'd0);
      @(negedge clk);
      chk("ready_hold", 64'(ready_o), 64'd1);
      chk("result_hold", result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("ready_drop", 64'(ready_o), 64'd0);
    chk("result_drop", result_o, 64'd0);
  endtask

  task automatic annul_test();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("stall_on", 64'(stall_o), 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("stall_annul", 64'(stall_o), 64'd0);
    chk("ready_annul", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_after_annul", 64'(ready_o), 64'd0);
  endtask

  task automatic reset_test();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("stall_pre_reset", 64'(stall_o), 64'd1);
    #2;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn       = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
`ifdef DIV_ZERO_DETECT_EN
    do_div(1'b0, 32'd7, 32'd0, 64'd0, 2);
`else
    do_div(1'b0, 32'd7, 32'd0, {32'd7, 32'hFFFFFFFF}, 33);
`endif
    annul_test();
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    reset_test();
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 33);
    do_div(1'b1, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 33);
    do_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
    do_div(1'b0, 32'd5, 32'd10, {32'd5, 32'd0}, 33);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
